// File: rtl/pmem_pkg.sv
// Shared types and constants for the program-memory bootloader.
package pmem_pkg;

  localparam int PMEM_AW = 8;
  localparam int PMEM_DW = 12;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_COUNT = 3'd1,
    LDR_HI    = 3'd2,
    LDR_LO    = 3'd3,
    LDR_CHK   = 3'd4,
    LDR_DONE  = 3'd5,
    LDR_ERR   = 3'd6
  } ldr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_HI      = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ldr_err_e;

endpackage

// File: rtl/ldr_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYCLES-th idle cycle is reached.
module ldr_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !clear && (cnt_q == TERM);

endmodule

// File: rtl/pmem_loader.sv
// Byte-stream bootloader: SYNC, COUNT, COUNT x (HI, LO), CHK frames are
// packed into 12-bit instructions and written to program memory.
//
// state     | meaning
// ----------+----------------------------------------------------------
// LDR_IDLE  | waiting for SYNC_BYTE, other bytes dropped
// LDR_COUNT | next byte is the instruction count (0 = 256)
// LDR_HI    | next byte carries instr[11:8] in its low nibble
// LDR_LO    | next byte carries instr[7:0]; write issued next cycle
// LDR_CHK   | next byte is the 8-bit wrap sum of COUNT and all HI/LO
// LDR_DONE  | one-cycle success pulse, input stalled
// LDR_ERR   | one-cycle abort pulse with Err_Code, input stalled
module pmem_loader
  import pmem_pkg::*;
#(
  parameter logic [7:0]         SYNC_BYTE      = 8'hA5,
  parameter logic [PMEM_AW-1:0] BASE_ADDR      = 8'h00,
  parameter int                 TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               In_Valid,
  input  logic [7:0]         In_Data,
  output logic               In_Ready,
  output logic               Load_En,
  output logic [PMEM_AW-1:0] Load_Addr,
  output logic [PMEM_DW-1:0] Load_Instr,
  output logic               CPU_Hold,
  output logic               Done,
  output logic               Error,
  output logic [1:0]         Err_Code
);

  ldr_state_e         state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [3:0]         nib_q, nib_d;
  logic [PMEM_AW-1:0] addr_q, addr_d;
  logic [PMEM_DW-1:0] instr_q, instr_d;
  logic               load_en_q, load_en_d;
  logic [1:0]         err_code_q, err_code_d;

  logic in_ready;
  logic in_frame;
  logic xfer;
  logic tmo_expire;

  assign xfer = In_Valid && in_ready;

  ldr_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_frame || xfer),
    .enable(in_frame && !xfer),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LDR_IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      nib_q      <= '0;
      addr_q     <= BASE_ADDR;
      instr_q    <= '0;
      load_en_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      nib_q      <= nib_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      load_en_q  <= load_en_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    nib_d      = nib_q;
    instr_d    = instr_q;
    load_en_d  = 1'b0;
    err_code_d = err_code_q;
    // Address advances in the cycle after each write strobe.
    addr_d     = load_en_q ? addr_q + 1'b1 : addr_q;

    case (state_q)
      LDR_IDLE: begin
        if (xfer && (In_Data == SYNC_BYTE)) state_d = LDR_COUNT;
      end
      LDR_COUNT: begin
        if (xfer) begin
          cnt_d   = (In_Data == 8'd0) ? 9'd256 : {1'b0, In_Data};
          sum_d   = In_Data;
          addr_d  = BASE_ADDR;
          state_d = LDR_HI;
        end
      end
      LDR_HI: begin
        if (xfer) begin
          if (In_Data[7:4] != 4'd0) begin
            err_code_d = ERR_HI;
            state_d    = LDR_ERR;
          end else begin
            nib_d   = In_Data[3:0];
            sum_d   = sum_q + In_Data;
            state_d = LDR_LO;
          end
        end
      end
      LDR_LO: begin
        if (xfer) begin
          sum_d     = sum_q + In_Data;
          instr_d   = {nib_q, In_Data};
          load_en_d = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          state_d   = (cnt_q == 9'd1) ? LDR_CHK : LDR_HI;
        end
      end
      LDR_CHK: begin
        if (xfer) begin
          if (In_Data == sum_q) begin
            state_d = LDR_DONE;
          end else begin
            err_code_d = ERR_CHK;
            state_d    = LDR_ERR;
          end
        end
      end
      LDR_DONE: state_d = LDR_IDLE;
      LDR_ERR:  state_d = LDR_IDLE;
      default:  state_d = LDR_IDLE;
    endcase

    if (in_frame && !xfer && tmo_expire) begin
      err_code_d = ERR_TIMEOUT;
      state_d    = LDR_ERR;
    end
  end

  always_comb begin
    in_ready = 1'b1;
    in_frame = 1'b0;
    Done     = 1'b0;
    Error    = 1'b0;
    case (state_q)
      LDR_COUNT, LDR_HI, LDR_LO, LDR_CHK: in_frame = 1'b1;
      LDR_DONE: begin
        in_ready = 1'b0;
        Done     = 1'b1;
      end
      LDR_ERR: begin
        in_ready = 1'b0;
        Error    = 1'b1;
      end
      default: ;
    endcase
  end

  assign In_Ready   = in_ready;
  assign CPU_Hold   = in_frame;
  assign Load_En    = load_en_q;
  assign Load_Addr  = addr_q;
  assign Load_Instr = instr_q;
  assign Err_Code   = err_code_q;

endmodule
